// File: rtl/sync_fifo_flex_if.sv
// Handshake and status bundle between a producer/consumer and sync_fifo_flex.
// The FIFO takes the slave side; whatever drives winc/rinc takes the master side.
interface sync_fifo_flex_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    logic                       winc;
    logic [WIDTH-1:0]           wdata;
    logic                       rinc;
    logic [WIDTH-1:0]           rdata;
    logic                       wfull;
    logic                       rempty;
    logic                       almost_full;
    logic                       almost_empty;
    logic [$clog2(DEPTH):0]     count;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output winc, wdata, rinc,
        input  rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc,
        output rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with fill count, programmable almost flags, overflow/underflow
// pulses and a choice of registered-read or first-word-fall-through output.
module sync_fifo_flex #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic            clk,
    input  logic            rst,
    sync_fifo_flex_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_COUNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_COUNT   = CW'(AE_LEVEL);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_fifo_flex: DEPTH must be a power of 2 and at least 2");
        end
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
            $error("sync_fifo_flex: AF_LEVEL must be in 1..DEPTH");
        end
        if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
            $error("sync_fifo_flex: AE_LEVEL must be in 0..DEPTH-1");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_next;
    logic             wfull_q;
    logic             rempty_q;
    logic             wen;
    logic             ren;

    // Accepts use the flags from before the edge, so full/empty gating also
    // rules out a same-address write/read collision.
    always_comb begin
        wen        = bus.winc & ~wfull_q;
        ren        = bus.rinc & ~rempty_q;
        count_next = count_q + CW'(wen) - CW'(ren);
    end

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[wptr] <= bus.wdata;
        end
    end

    // All status outputs are registered from count_next so they describe the
    // state right after the edge that produced it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr             <= '0;
            rptr             <= '0;
            count_q          <= '0;
            wfull_q          <= 1'b0;
            rempty_q         <= 1'b1;
            bus.almost_full  <= 1'b0;
            bus.almost_empty <= 1'b1;
            bus.overflow     <= 1'b0;
            bus.underflow    <= 1'b0;
        end else begin
            if (wen) begin
                wptr <= wptr + 1'b1;
            end
            if (ren) begin
                rptr <= rptr + 1'b1;
            end
            count_q          <= count_next;
            wfull_q          <= (count_next == FULL_COUNT);
            rempty_q         <= (count_next == '0);
            bus.almost_full  <= (count_next >= AF_COUNT);
            bus.almost_empty <= (count_next <= AE_COUNT);
            bus.overflow     <= bus.winc & wfull_q;
            bus.underflow    <= bus.rinc & rempty_q;
        end
    end

    assign bus.count  = count_q;
    assign bus.wfull  = wfull_q;
    assign bus.rempty = rempty_q;

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.rdata = mem[rptr];
        end else begin : g_registered
            logic [WIDTH-1:0] rdata_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q <= '0;
                end else if (ren) begin
                    rdata_q <= mem[rptr];
                end
            end

            assign bus.rdata = rdata_q;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Drives a registered-read FIFO (default levels) and a FWFT FIFO (AF=12, AE=3)
// with the same stimulus and compares both against a queue-based model.
module tb_sync_fifo_flex;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_rdata_reg;
    logic       exp_ovf;
    logic       exp_udf;

    sync_fifo_flex_if #(.WIDTH(8), .DEPTH(DEPTH)) bus_a ();
    sync_fifo_flex_if #(.WIDTH(8), .DEPTH(DEPTH)) bus_b ();

    sync_fifo_flex #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    sync_fifo_flex #(.WIDTH(8), .DEPTH(DEPTH), .AF_LEVEL(12), .AE_LEVEL(3), .FWFT(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, advance the model on the edge, check both DUTs.
    task automatic applyStimulus(input logic r, input logic w, input logic [7:0] wd, input logic rd);
        int  n;
        logic full;
        logic empty;
        rst         = r;
        bus_a.winc  = w;
        bus_a.wdata = wd;
        bus_a.rinc  = rd;
        bus_b.winc  = w;
        bus_b.wdata = wd;
        bus_b.rinc  = rd;
        @(posedge clk);
        #1;
        full  = (exp_q.size() == DEPTH);
        empty = (exp_q.size() == 0);
        if (r) begin
            exp_q.delete();
            exp_rdata_reg = 8'h00;
            exp_ovf       = 1'b0;
            exp_udf       = 1'b0;
        end else begin
            exp_ovf = w && full;
            exp_udf = rd && empty;
            if (rd && !empty) exp_rdata_reg = exp_q.pop_front();
            if (w && !full)   exp_q.push_back(wd);
        end
        n = exp_q.size();
        checkOutput("a_count",  32'(bus_a.count),      32'(n));
        checkOutput("a_wfull",  32'(bus_a.wfull),      32'(n == DEPTH));
        checkOutput("a_rempty", 32'(bus_a.rempty),     32'(n == 0));
        checkOutput("a_afull",  32'(bus_a.almost_full),  32'(n >= DEPTH - 2));
        checkOutput("a_aempty", 32'(bus_a.almost_empty), 32'(n <= 2));
        checkOutput("a_ovf",    32'(bus_a.overflow),   32'(exp_ovf));
        checkOutput("a_udf",    32'(bus_a.underflow),  32'(exp_udf));
        checkOutput("a_rdata",  32'(bus_a.rdata),      32'(exp_rdata_reg));
        checkOutput("b_count",  32'(bus_b.count),      32'(n));
        checkOutput("b_wfull",  32'(bus_b.wfull),      32'(n == DEPTH));
        checkOutput("b_rempty", 32'(bus_b.rempty),     32'(n == 0));
        checkOutput("b_afull",  32'(bus_b.almost_full),  32'(n >= 12));
        checkOutput("b_aempty", 32'(bus_b.almost_empty), 32'(n <= 3));
        checkOutput("b_ovf",    32'(bus_b.overflow),   32'(exp_ovf));
        checkOutput("b_udf",    32'(bus_b.underflow),  32'(exp_udf));
        if (n > 0) checkOutput("b_rdata_fwft", 32'(bus_b.rdata), 32'(exp_q[0]));
    endtask

    initial begin
        logic [7:0] d;
        int wbias;
        exp_rdata_reg = 8'h00;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;

        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

        // Fill with 0x01..0x10, then one write too many
        for (int i = 1; i <= 16; i++) applyStimulus(1'b0, 1'b1, 8'(i), 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h77, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

        // Drain, then one read too many; registered rdata must hold 0x10
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("hold_after_udf", 32'(bus_a.rdata), 32'h10);

        // Pointer wrap-around
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

        // Simultaneous read/write at count=5, from empty, and from full
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 8'($urandom), 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h5A, 1'b1);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1);

        // FWFT fall-through from empty, then read with a second entry queued
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hA5, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("fwft_first", 32'(bus_b.rdata), 32'hA5);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'hC3, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h3C, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("fwft_advance", 32'(bus_b.rdata), 32'h3C);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);

        // Threshold crossings up to 13 and down again, then reset at count=9
        for (int i = 0; i < 13; i++) applyStimulus(1'b0, 1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h11, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'hB7, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("post_reset_first", 32'(bus_a.rdata), 32'hB7);

        // Randomised traffic with alternating fill/drain bias and rare resets
        for (int i = 0; i < 1200; i++) begin
            wbias = ((i / 100) % 2 == 0) ? 70 : 30;
            d = 8'($urandom);
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 99) < wbias, d,
                          $urandom_range(0, 99) >= wbias);
        end

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
- Single-clock, parametrised FIFO with internal storage. Successor to the dual-clock RAM/FIFO pair for blocks that live in one clock domain.
- Adds a fill count, programmable almost-full and almost-empty flags, overflow and underflow pulses, and a selectable output mode: registered read or first-word-fall-through (FWFT).
- Sits between a producer and a consumer in the same clock domain, using the same winc/rinc handshake style as the async FIFO.

Parameters:
- WIDTH, 8, data width in bits (≥1).
- DEPTH, 16, number of entries. Must be a power of 2 and ≥2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL. Range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL. Range 0..DEPTH-1.
- FWFT, 0, output mode. 0 = registered read (1-cycle latency); 1 = head of queue always visible on rdata.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- winc  in  1  write request.
- wdata  in  WIDTH  write data.
- rinc  in  1  read request (pop).
- rdata  out  WIDTH  read data.
- wfull  out  1  FIFO full.
- rempty  out  1  FIFO empty.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write attempted while full.
- underflow  out  1  one-cycle pulse: read attempted while empty.

Behaviour:
- Accept conditions use flag values before the edge:
  - wen = winc & ~wfull
  - ren = rinc & ~rempty
- Pointers:
  - wptr and rptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Occupancy is tracked by the count register (count_next = count + wen − ren), not by pointer comparison.
- Status outputs:
  - Every status output (wfull, rempty, almost_full, almost_empty, count) is registered and derived from count_next.
  - Each reflects the result of the current edge immediately after that edge.
  - wfull = (count == DEPTH); rempty = (count == 0).
- Simultaneous winc and rinc:
  - Not full and not empty: both are accepted and count is unchanged.
  - Full: only the read is accepted and overflow pulses.
  - Empty: only the write is accepted and underflow pulses.
- Overflow and underflow:
  - overflow = registered (winc & wfull); underflow = registered (rinc & rempty).
  - Each is high for exactly one cycle per offending request cycle. They are not sticky.
- FWFT=0 (registered read):
  - On ren, rdata ← mem[rptr] at that edge, so data is valid the cycle after rinc is accepted.
  - rdata holds its value otherwise, including on an underflow attempt.
- FWFT=1 (fall-through):
  - rdata = mem[rptr], read combinationally from the storage array.
  - Valid whenever rempty=0; the first write appears on rdata in the cycle after the write edge.
  - ren advances to the next entry.
  - rdata is don't-care while rempty=1; the bench must not check it then.
- Write/read collisions:
  - Writes go to mem[wptr] on wen.
  - A write and a read of the same address in the same cycle cannot occur unless count is 0 or DEPTH, and ren/wen gating excludes the hazardous case. No bypass path is required.
- Reset (rst=1 at a rising edge):
  - wptr=0, rptr=0, count=0, rempty=1, wfull=0, almost_full=0, almost_empty=1, overflow=0, underflow=0, rdata=0 (FWFT=0).
  - Storage contents are not reset.
  - Reset overrides winc/rinc in the same cycle.
  - Reset mid-operation discards all queued data; the first post-reset write lands at address 0.
- Elaboration checks:
  - DEPTH must be a power of 2 and ≥2.
  - AF_LEVEL must be in 1..DEPTH; AE_LEVEL must be in 0..DEPTH-1.
  - A violation triggers an elaboration-time error or fatal.

Test Plan:
1. Reset, FWFT=0, DEPTH=16 → write 0x01..0x10 on 16 consecutive cycles.
   - After the 16th edge: wfull=1, count=16, almost_full=1.
   - A 17th winc produces overflow=1 for one cycle; count stays 16.
2. From full, 16 consecutive rinc → rdata sequence 0x01..0x10, each value one cycle after its rinc.
   - rempty=1 after the 16th edge.
   - A further rinc produces underflow=1 for one cycle; rdata holds 0x10.
3. Wrap-around: write 10, read 10, write 12, read 12 → read order matches write order across the pointer wrap; count returns to 0.
4. Simultaneous winc and rinc:
   - With count=5 for 20 cycles: count stays 5 throughout and data order is preserved.
   - From empty with both asserted: only the write is accepted, count=1, underflow=1.
   - From full with both asserted: only the read is accepted, count=15, overflow=1.
5. FWFT=1, write 0xA5 to an empty FIFO → rdata=0xA5 and rempty=0 the next cycle with no rinc.
   - rinc then gives rempty=1; with a second entry queued, rdata advances to it on the same edge.
6. Thresholds AF_LEVEL=12, AE_LEVEL=3 → almost_empty deasserts on the edge count goes 3→4; almost_full asserts on 11→12.
   - rst asserted at count=9 → next cycle count=0, rempty=1, almost_empty=1, almost_full=0.
